// File: rtl/mul_issue_if.sv
// mul_issue_if: groups the decode-side issue signals, the multiplier operand and
// product wires, the register-file write-back handshake and the hazard-stall
// exports of the multiply issue sequencer.
//   slave  : the sequencer side (mul_issue)
//   master : the surrounding core side (decode, multiplier, register file)
// Signals:
//   start, rs_in, rd_in, dest_in, flush   issue request from decode
//   ready                                 sequencer can accept start this cycle
//   mul_a, mul_b / mul_q                  operands to / product from the multiplier
//   wb_valid, wb_addr, wb_data / wb_ack   register-file write request / accept
//   busy, pend_addr                       pending-operation info for hazard logic
interface mul_issue_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [WIDTH-1:0]  rs_in;
  logic [WIDTH-1:0]  rd_in;
  logic [ADDR_W-1:0] dest_in;
  logic              flush;
  logic              ready;
  logic [WIDTH-1:0]  mul_a;
  logic [WIDTH-1:0]  mul_b;
  logic [WIDTH-1:0]  mul_q;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              wb_ack;
  logic              busy;
  logic [ADDR_W-1:0] pend_addr;

  modport slave (
    input  start, rs_in, rd_in, dest_in, flush, mul_q, wb_ack,
    output ready, mul_a, mul_b, wb_valid, wb_addr, wb_data, busy, pend_addr
  );

  modport master (
    output start, rs_in, rd_in, dest_in, flush, mul_q, wb_ack,
    input  ready, mul_a, mul_b, wb_valid, wb_addr, wb_data, busy, pend_addr
  );
endinterface

// File: rtl/mul_issue.sv
// mul_issue: multi-cycle issue and write-back sequencer for the external
// combinational multiplier. Operands and destination are latched on start,
// held on mul_a/mul_b for SETTLE_CYCLES cycles, then the product (low WIDTH
// bits, computed outside) is registered and offered on the write-back port
// until the register file acks it.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      mul_issue_if.slave (issue, multiplier, write-back, hazard signals)
// Parameters:
//   WIDTH          operand/product width
//   ADDR_W         register index width
//   SETTLE_CYCLES  settle time before the product is sampled, 1..15
module mul_issue #(
  parameter int WIDTH         = 16,
  parameter int ADDR_W        = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  mul_issue_if.slave bus
);

  localparam int CNT_W = 4;
  // Counter starts at SETTLE_CYCLES-1 so that the sample happens in the
  // SETTLE cycle where it reads zero, giving exactly SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WB     = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [WIDTH-1:0]  mul_a_r;
  logic [WIDTH-1:0]  mul_b_r;
  logic [ADDR_W-1:0] dest_r;
  logic [WIDTH-1:0]  wb_data_r;
  logic              wb_valid_r;
  logic              accept_s;
  logic              sample_s;
  logic              commit_s;

  // Next-state decode and the three datapath events (accept, sample, commit).
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    sample_s     = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // start together with flush is dropped
        if (bus.start && !bus.flush) begin
          accept_s     = 1'b1;
          state_next_s = SETTLE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETTLE: begin
        if (bus.flush) begin
          state_next_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          sample_s     = 1'b1;
          state_next_s = WB;
        end else begin
          state_next_s = SETTLE;
        end
      end
      WB: begin
        // wb_valid is high throughout WB; flush cannot cancel a committed write
        if (bus.wb_ack) begin
          commit_s     = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = WB;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand, destination, settle counter and write-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 4'd0;
      mul_a_r    <= {WIDTH{1'b0}};
      mul_b_r    <= {WIDTH{1'b0}};
      dest_r     <= {ADDR_W{1'b0}};
      wb_data_r  <= {WIDTH{1'b0}};
      wb_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        mul_a_r <= bus.rs_in;
        mul_b_r <= bus.rd_in;
        dest_r  <= bus.dest_in;
        cnt_r   <= CNT_LOAD;
      end else if ((state_r == SETTLE) && !bus.flush && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (sample_s) begin
        wb_data_r  <= bus.mul_q;
        wb_valid_r <= 1'b1;
      end else if (commit_s) begin
        wb_valid_r <= 1'b0;
      end
    end
  end

  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;
  assign bus.wb_valid  = wb_valid_r;
  assign bus.wb_addr   = dest_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.pend_addr = dest_r;
  assign bus.busy      = (state_r != IDLE);
  // ready is forced low while reset is asserted, independent of state
  assign bus.ready     = (state_r == IDLE) && !rst;

endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: self-checking bench for mul_issue. Three instances share the
// same stimulus: SETTLE_CYCLES=2 (main, scoreboarded), 1 and 4 (latency sweep).
// Each instance gets a behavioural multiplier on mul_a/mul_b -> mul_q.
module tb_mul_issue;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [WIDTH-1:0] rs_in;
  logic [WIDTH-1:0] rd_in;
  logic [ADDR_W-1:0] dest_in;
  logic flush;
  logic wb_ack;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mul_issue_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus2 ();
  mul_issue_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus1 ();
  mul_issue_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus4 ();

  logic [31:0] prod2;
  logic [31:0] prod1;
  logic [31:0] prod4;

  assign prod2 = 32'(bus2.mul_a) * 32'(bus2.mul_b);
  assign prod1 = 32'(bus1.mul_a) * 32'(bus1.mul_b);
  assign prod4 = 32'(bus4.mul_a) * 32'(bus4.mul_b);
  assign bus2.mul_q = prod2[15:0];
  assign bus1.mul_q = prod1[15:0];
  assign bus4.mul_q = prod4[15:0];

  assign bus2.start = start;   assign bus1.start = start;   assign bus4.start = start;
  assign bus2.rs_in = rs_in;   assign bus1.rs_in = rs_in;   assign bus4.rs_in = rs_in;
  assign bus2.rd_in = rd_in;   assign bus1.rd_in = rd_in;   assign bus4.rd_in = rd_in;
  assign bus2.dest_in = dest_in; assign bus1.dest_in = dest_in; assign bus4.dest_in = dest_in;
  assign bus2.flush = flush;   assign bus1.flush = flush;   assign bus4.flush = flush;
  assign bus2.wb_ack = wb_ack; assign bus1.wb_ack = wb_ack; assign bus4.wb_ack = wb_ack;

  mul_issue #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));
  mul_issue #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  mul_issue #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[15:0];
  endfunction

  // Inputs change 2 time units after the rising edge; outputs sampled on falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input logic [15:0] exp, input bit push);
    exp_t e;
    start   = 1'b1;
    rs_in   = a;
    rd_in   = b;
    dest_in = d;
    if (push) begin
      e.addr = d;
      e.data = exp;
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard: every accepted write-back on the main instance is compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus2.wb_valid && wb_ack) begin
      if (sb_q.size() == 0) begin
        check_eq("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("wb_addr", 32'(bus2.wb_addr), 32'(e.addr));
        check_eq("wb_data", 32'(bus2.wb_data), 32'(e.data));
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1; start = 1'b0; rs_in = 16'h0000; rd_in = 16'h0000;
    dest_in = 3'd0; flush = 1'b0; wb_ack = 1'b0;

    // Reset values
    step(); step();
    @(negedge clk);
    check_eq("rst_ready_low", 32'(bus2.ready), 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(bus2.ready), 32'd1);
    check_eq("rst_busy", 32'(bus2.busy), 32'd0);
    check_eq("rst_wb_valid", 32'(bus2.wb_valid), 32'd0);
    check_eq("rst_mul_a", 32'(bus2.mul_a), 32'd0);
    check_eq("rst_mul_b", 32'(bus2.mul_b), 32'd0);
    check_eq("rst_wb_data", 32'(bus2.wb_data), 32'd0);
    check_eq("rst_wb_addr", 32'(bus2.wb_addr), 32'd0);
    check_eq("rst_pend_addr", 32'(bus2.pend_addr), 32'd0);
    step();

    // Basic 3 x 5 -> 0x000F at r2, wb_valid only in cycle 3
    wb_ack = 1'b1;
    drive_op(16'h0003, 16'h0005, 3'd2, 16'h000F, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("basic_wb_valid", 32'(bus2.wb_valid), 32'(k == 3));
      if (k == 1) begin
        check_eq("basic_busy", 32'(bus2.busy), 32'd1);
        check_eq("basic_pend_addr", 32'(bus2.pend_addr), 32'd2);
        check_eq("basic_ready_busy", 32'(bus2.ready), 32'd0);
      end
      if (k == 4) begin
        check_eq("basic_ready_back", 32'(bus2.ready), 32'd1);
      end
      step();
      start = 1'b0;
    end

    // Truncation, back-to-back at SETTLE_CYCLES+2 spacing
    drive_op(16'h1234, 16'h0100, 3'd5, 16'h3400, 1'b1);
    step(); start = 1'b0;
    step(); step(); step();
    @(negedge clk);
    check_eq("b2b_ready", 32'(bus2.ready), 32'd1);
    drive_op(16'hFFFF, 16'hFFFF, 3'd7, 16'h0001, 1'b1);
    step(); start = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      drive_op(ra, rb, 3'($urandom_range(0, 7)), ref_mul(ra, rb), 1'b1);
      step(); start = 1'b0;
      step(); step(); step();
    end

    // Back-pressure: ack low 5 cycles, start pulse in WB ignored
    wb_ack = 1'b0;
    drive_op(16'h00AB, 16'h0010, 3'd3, 16'h0AB0, 1'b1);
    step(); start = 1'b0;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        start = 1'b1; rs_in = 16'h5555; rd_in = 16'h7777; dest_in = 3'd6;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check_eq("bp_wb_valid", 32'(bus2.wb_valid), 32'd1);
      check_eq("bp_wb_data", 32'(bus2.wb_data), 32'h0AB0);
      check_eq("bp_wb_addr", 32'(bus2.wb_addr), 32'd3);
      check_eq("bp_mul_a", 32'(bus2.mul_a), 32'h00AB);
      check_eq("bp_mul_b", 32'(bus2.mul_b), 32'h0010);
      step();
    end
    start = 1'b0; wb_ack = 1'b1;
    step(); wb_ack = 1'b0;
    @(negedge clk);
    check_eq("bp_busy_after", 32'(bus2.busy), 32'd0);
    check_eq("bp_ready_after", 32'(bus2.ready), 32'd1);
    check_eq("bp_pend_idle", 32'(bus2.pend_addr), 32'd3);
    step();

    // Flush in first SETTLE cycle: no write-back
    wb_ack = 1'b1;
    drive_op(16'h0009, 16'h0009, 3'd1, 16'h0051, 1'b0);
    step(); start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check_eq("flush_busy_settle", 32'(bus2.busy), 32'd1);
    step(); flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy_drop", 32'(bus2.busy), 32'd0);
    check_eq("flush_ready", 32'(bus2.ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check_eq("flush_no_wb", 32'(bus2.wb_valid), 32'd0);
    end
    step();

    // start together with flush is dropped
    drive_op(16'h0004, 16'h0004, 3'd2, 16'h0010, 1'b0);
    flush = 1'b1;
    step(); start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("start_flush_drop", 32'(bus2.busy), 32'd0);
    step();

    // Flush during WB still completes the write
    wb_ack = 1'b0;
    drive_op(16'h0002, 16'h0003, 3'd1, 16'h0006, 1'b1);
    step(); start = 1'b0;
    step(); step();
    flush = 1'b1;
    step(); flush = 1'b0; wb_ack = 1'b1;
    @(negedge clk);
    check_eq("flush_wb_valid", 32'(bus2.wb_valid), 32'd1);
    step(); wb_ack = 1'b0;
    @(negedge clk);
    check_eq("flush_wb_done", 32'(bus2.busy), 32'd0);
    step();

    // Reset in WB loses the pending write
    drive_op(16'h0007, 16'h0009, 3'd4, 16'h003F, 1'b1);
    step(); start = 1'b0;
    step(); step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_ready_low", 32'(bus2.ready), 32'd0);
    step(); rst = 1'b0; sb_q.delete();
    @(negedge clk);
    check_eq("rstmid_wb_valid", 32'(bus2.wb_valid), 32'd0);
    check_eq("rstmid_busy", 32'(bus2.busy), 32'd0);
    check_eq("rstmid_mul_a", 32'(bus2.mul_a), 32'd0);
    check_eq("rstmid_wb_data", 32'(bus2.wb_data), 32'd0);
    check_eq("rstmid_pend", 32'(bus2.pend_addr), 32'd0);
    check_eq("rstmid_ready", 32'(bus2.ready), 32'd1);
    step();

    // Latency sweep across SETTLE_CYCLES = 1, 2, 4
    rst = 1'b1;
    step(); step();
    rst = 1'b0; wb_ack = 1'b1;
    drive_op(16'h0011, 16'h0003, 3'd6, 16'h0033, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_eq("sweep1_wb_valid", 32'(bus1.wb_valid), 32'(k == 2));
      check_eq("sweep4_wb_valid", 32'(bus4.wb_valid), 32'(k == 5));
      check_eq("sweep1_busy", 32'(bus1.busy), 32'((k >= 1) && (k <= 2)));
      check_eq("sweep4_busy", 32'(bus4.busy), 32'((k >= 1) && (k <= 5)));
      if (bus1.busy) check_eq("sweep1_pend", 32'(bus1.pend_addr), 32'd6);
      if (bus4.busy) check_eq("sweep4_pend", 32'(bus4.pend_addr), 32'd6);
      if (k == 2) check_eq("sweep1_data", 32'(bus1.wb_data), 32'h0033);
      if (k == 5) check_eq("sweep4_data", 32'(bus4.wb_data), 32'h0033);
      step();
      start = 1'b0;
    end
    wb_ack = 1'b0;

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
# mul_issue

Multi-cycle issue and write-back sequencer for the combinational 16-bit multiplier in the non-pipelined Harvard core. It latches operands and a destination register index from decode on a start pulse. It holds the operands stable on the multiplier inputs for a fixed number of settle cycles, registers the product, and presents it to the register-file write port with a valid/ack handshake. The block also exports busy/pending-destination for the hazard stall logic.

## Interface
- `WIDTH`, 16, operand and product width (product truncated to low WIDTH bits)
- `ADDR_W`, 3, register index width
- `SETTLE_CYCLES`, 2, cycles operands are held before the product is sampled; legal range 1..15
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: issue request from decode
- `rs_in` in WIDTH: multiplicand
- `rd_in` in WIDTH: multiplier
- `dest_in` in ADDR_W: destination register
- `flush` in 1: abort an in-flight operation
- `ready` out 1: block can accept `start` this cycle
- `mul_a` out WIDTH: to multiplier `rs`
- `mul_b` out WIDTH: to multiplier `rd`
- `mul_q` in WIDTH: from multiplier `q`
- `wb_valid` out 1: write-back request
- `wb_addr` out ADDR_W: write-back register index
- `wb_data` out WIDTH: write-back value
- `wb_ack` in 1: register file accepts write this cycle
- `busy` out 1: operation pending (state != IDLE)
- `pend_addr` out ADDR_W: destination of the pending operation, for hazard compare

## Operation
- FSM states: IDLE, SETTLE, WB. Reset state is IDLE.
- IDLE: `ready`=1. On `start`&&!`flush`, latch `rs_in`→`mul_a`, `rd_in`→`mul_b`, `dest_in`→dest register, and load counter with SETTLE_CYCLES-1, then go to SETTLE. `start` with `flush` in the same cycle is dropped.
- SETTLE: `mul_a`/`mul_b` held constant. If counter≠0, decrement. If counter==0, register `mul_q`→`wb_data` and go to WB. `flush` returns the FSM to IDLE and discards the result; no write-back occurs.
- WB: `wb_valid`=1, `wb_addr`=dest, `wb_data` stable. Hold until `wb_ack`. On `wb_valid`&&`wb_ack`, go to IDLE. `flush` in WB is ignored because the write is already committed.
- `start` outside IDLE is ignored. There is no queuing.
- `wb_ack` outside WB is ignored.
- `busy`=1 in SETTLE and WB. `pend_addr`=dest register in all states.
- Arithmetic: the product is the low WIDTH bits of rs×rd, computed externally. The block performs no arithmetic beyond the counter.

## Timing
- Reset values: state IDLE, `mul_a`=0, `mul_b`=0, `wb_data`=0, `wb_addr`=0, `pend_addr`=0, counter=0, `wb_valid`=0, `busy`=0. `ready`=0 while `rst` is high and 1 in the first cycle after.
- `rst` mid-operation returns the FSM to IDLE on the next edge, clears all outputs, and loses the pending write.
- Latency: with `start` sampled in cycle 0, `wb_valid` rises in cycle SETTLE_CYCLES+1; for the default this is cycle 3.
- `mul_q` is sampled at the end of the last SETTLE cycle, giving SETTLE_CYCLES full cycles of settle time after the operand registers update.
- Throughput: the earliest next `start` is the cycle after `wb_ack`. Back-to-back operations with immediate ack take SETTLE_CYCLES+2 cycles per operation.
- `wb_valid`, `wb_addr`, `wb_data` are registered outputs. `ready` decodes the state combinationally.

## Test plan
- Basic: `rs_in`=0x0003, `rd_in`=0x0005, `dest_in`=2, `start` in cycle 0, `wb_ack` tied 1 → `wb_valid`=1 only in cycle 3 with `wb_data`=0x000F, `wb_addr`=2; `ready` returns to 1 in cycle 4.
- Truncation: 0x1234×0x0100 → `wb_data`=0x3400. Also 0xFFFF×0xFFFF → 0x0001.
- Back-pressure: `wb_ack` held low for 5 cycles in WB → `wb_valid`/`wb_data` stable throughout; a `start` pulsed during WB is ignored, and `mul_a`/`mul_b` are unchanged.
- Flush: `flush` in cycle 1 of SETTLE → IDLE next cycle, no `wb_valid` ever asserted, `busy` drops. A `flush` pulsed during WB still completes the write.
- Reset mid-op: `rst` asserted in WB → next cycle `wb_valid`=0, `busy`=0, `mul_a`=0, `ready`=1 after `rst` deasserts.
- Parameter sweep: SETTLE_CYCLES=1 and 4 → `wb_valid` rises in cycles 2 and 5 respectively; `pend_addr` equals `dest_in` while `busy`.
